// File: rtl/trolley_system_button_debounce_pkg.sv
// Shared types and default constants for the trolley push-button conditioning path.
package trolley_system_button_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } btn_state_t;

  localparam int BTN_DEBOUNCE_CYCLES_DEF   = 500000;     // 10 ms at 50 MHz
  localparam int BTN_LONG_PRESS_CYCLES_DEF = 100000000;  // 2 s at 50 MHz
  localparam int BTN_SYNC_STAGES_DEF       = 2;

endpackage

// File: rtl/trolley_system_button_debounce_if.sv
// Pad-side and conditioned button signals; long_press exists only with
// TROLLEY_BUTTON_LONG_PRESS_EN defined.
interface trolley_system_button_debounce_if;
  logic button_raw;
  logic button_clean;
  logic press_pulse;
  logic release_pulse;
`ifdef TROLLEY_BUTTON_LONG_PRESS_EN
  logic long_press;

  modport master (output button_raw, input button_clean, press_pulse, release_pulse, long_press);
  modport slave  (input button_raw, output button_clean, press_pulse, release_pulse, long_press);
`else
  modport master (output button_raw, input button_clean, press_pulse, release_pulse);
  modport slave  (input button_raw, output button_clean, press_pulse, release_pulse);
`endif
endinterface

// File: rtl/trolley_system_button_debounce_sync.sv
// N-stage reset-able synchroniser for asynchronous pad inputs; reset value is
// the idle level so a quiet pad never glitches out of reset.
module trolley_system_button_sync #(
  parameter int               STAGES  = 2,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {STAGES{RST_VAL}};
    else     sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/trolley_system_button_debounce.sv
// Push-button conditioner: synchronise, debounce with a full-window hold FSM,
// emit clean level plus press/release strobes. TROLLEY_BUTTON_LONG_PRESS_EN adds long_press.
module trolley_system_button_debounce
  import trolley_system_button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = BTN_DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES       = BTN_SYNC_STAGES_DEF,
  parameter bit RAW_ACTIVE_LOW    = 1'b1,
  parameter int LONG_PRESS_CYCLES = BTN_LONG_PRESS_CYCLES_DEF
) (
  input logic                            clk,
  input logic                            reset,
  trolley_system_button_debounce_if.slave btn
);

  localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || SYNC_STAGES < 2 || LONG_PRESS_CYCLES < 2) begin : g_bad_param
    $error("trolley_system_button_debounce: parameter below legal minimum of 2");
  end

  logic pressed_raw, s;
  btn_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic clean_q, clean_d, press_q, press_d, release_q, release_d;

  assign pressed_raw = btn.button_raw ^ RAW_ACTIVE_LOW;

  trolley_system_button_sync #(
    .STAGES  (SYNC_STAGES),
    .WIDTH   (1),
    .RST_VAL (1'b0)
  ) u_sync (
    .clk (clk),
    .rst (reset),
    .d   (pressed_raw),
    .q   (s)
  );

  // Any disagreement in a WAIT state throws away the whole window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RELEASED:
        if (s) begin state_d = WAIT_PRESS; cnt_d = '0; end
      WAIT_PRESS:
        if (!s)                    begin state_d = RELEASED; cnt_d = '0; end
        else if (cnt_q == CNT_MAX) begin state_d = PRESSED;  cnt_d = '0; end
        else                       cnt_d = cnt_q + CNT_W'(1);
      PRESSED:
        if (!s) begin state_d = WAIT_RELEASE; cnt_d = '0; end
      WAIT_RELEASE:
        if (s)                     begin state_d = PRESSED;  cnt_d = '0; end
        else if (cnt_q == CNT_MAX) begin state_d = RELEASED; cnt_d = '0; end
        else                       cnt_d = cnt_q + CNT_W'(1);
      default: begin state_d = RELEASED; cnt_d = '0; end
    endcase
    clean_d   = (state_d == PRESSED) || (state_d == WAIT_RELEASE);
    press_d   = clean_d & ~clean_q;
    release_d = ~clean_d & clean_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      clean_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clean_q   <= clean_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn.button_clean  = clean_q;
  assign btn.press_pulse   = press_q;
  assign btn.release_pulse = release_q;

`ifdef TROLLEY_BUTTON_LONG_PRESS_EN
  localparam int              LP_W   = $clog2(LONG_PRESS_CYCLES);
  localparam logic [LP_W-1:0] LP_MAX = LP_W'(LONG_PRESS_CYCLES - 1);

  logic [LP_W-1:0] lp_cnt_q, lp_cnt_d;
  logic lp_fired_q, lp_fired_d, long_q, long_d;

  // Counter saturates at LP_MAX; the fired flag holds until a full release.
  always_comb begin
    lp_cnt_d   = lp_cnt_q;
    lp_fired_d = lp_fired_q;
    long_d     = 1'b0;
    if (state_d == RELEASED || state_d == WAIT_PRESS) begin
      lp_cnt_d   = '0;
      lp_fired_d = 1'b0;
    end else if (state_d == PRESSED && state_q != PRESSED) begin
      lp_cnt_d = '0;
    end else if (lp_cnt_q == LP_MAX) begin
      long_d     = ~lp_fired_q;
      lp_fired_d = 1'b1;
    end else begin
      lp_cnt_d = lp_cnt_q + LP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lp_cnt_q   <= '0;
      lp_fired_q <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      lp_cnt_q   <= lp_cnt_d;
      lp_fired_q <= lp_fired_d;
      long_q     <= long_d;
    end
  end

  assign btn.long_press = long_q;
`endif

endmodule

// File: tb/tb_trolley_system_button_debounce.sv
// Directed bench for the button conditioner with a 4-cycle debounce window.
module tb_trolley_system_button_debounce;

  localparam int DEB = 4;
  localparam int SYN = 2;
  localparam int LPC = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  trolley_system_button_debounce_if btn_if ();

  trolley_system_button_debounce #(
    .DEBOUNCE_CYCLES   (DEB),
    .SYNC_STAGES       (SYN),
    .RAW_ACTIVE_LOW    (1'b1),
    .LONG_PRESS_CYCLES (LPC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_if)
  );

  int tests = 0;
  int fails = 0;
  int n_press = 0;
  int n_rel = 0;
  int n_long = 0;

  always @(negedge clk) begin
    if (btn_if.press_pulse === 1'b1)   n_press <= n_press + 1;
    if (btn_if.release_pulse === 1'b1) n_rel   <= n_rel + 1;
`ifdef TROLLEY_BUTTON_LONG_PRESS_EN
    if (btn_if.long_press === 1'b1)    n_long  <= n_long + 1;
`endif
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int l0;
    reset = 1'b1;
    btn_if.button_raw = 1'b1;
    step(3);
    chk("rst_clean",   32'(btn_if.button_clean),  0);
    chk("rst_press",   32'(btn_if.press_pulse),   0);
    chk("rst_release", 32'(btn_if.release_pulse), 0);

    reset = 1'b0;
    step(8);
    chk("idle_clean",  32'(btn_if.button_clean), 0);
    chk("idle_npress", n_press, 0);

    // Clean press: commit on the 7th edge after the pad change (edge 1 samples)
    btn_if.button_raw = 1'b0;
    step(6);
    chk("press_early_clean", 32'(btn_if.button_clean), 0);
    chk("press_early_pulse", 32'(btn_if.press_pulse),  0);
    step(1);
    chk("press_clean", 32'(btn_if.button_clean), 1);
    chk("press_pulse", 32'(btn_if.press_pulse),  1);
    step(1);
    chk("press_pulse_w", 32'(btn_if.press_pulse), 0);
    chk("press_count",   n_press, 1);

    // Release
    btn_if.button_raw = 1'b1;
    step(6);
    chk("rel_early_clean", 32'(btn_if.button_clean), 1);
    step(1);
    chk("rel_clean", 32'(btn_if.button_clean),  0);
    chk("rel_pulse", 32'(btn_if.release_pulse), 1);
    step(1);
    chk("rel_pulse_w", 32'(btn_if.release_pulse), 0);
    chk("rel_count",   n_rel, 1);

    // Short glitch, 3 cycles pressed
    btn_if.button_raw = 1'b0;
    step(3);
    btn_if.button_raw = 1'b1;
    step(12);
    chk("glitch_clean",  32'(btn_if.button_clean), 0);
    chk("glitch_npress", n_press, 1);
    chk("glitch_nrel",   n_rel, 1);

    // Bounce every 2 cycles, then settle pressed
    for (int i = 0; i < 10; i++) begin
      btn_if.button_raw = i[0];
      step(2);
    end
    btn_if.button_raw = 1'b0;
    step(6);
    chk("bounce_early_clean", 32'(btn_if.button_clean), 0);
    chk("bounce_npress",      n_press, 1);
    step(1);
    chk("bounce_clean", 32'(btn_if.button_clean), 1);
    chk("bounce_pulse", 32'(btn_if.press_pulse),  1);
    step(4);
    chk("bounce_count", n_press, 2);

    // Reset while pressed: outputs drop without waiting for an edge
    reset = 1'b1;
    #2;
    chk("rstp_clean", 32'(btn_if.button_clean), 0);
    step(2);
    reset = 1'b0;
    chk("rstp_nrel", n_rel, 1);
    step(6);
    chk("rstp_early_clean", 32'(btn_if.button_clean), 0);
    step(1);
    chk("rstp_clean2", 32'(btn_if.button_clean), 1);
    chk("rstp_pulse",  32'(btn_if.press_pulse),  1);

    // Reset while in WAIT_PRESS
    btn_if.button_raw = 1'b1;
    step(10);
    chk("rstw_released", 32'(btn_if.button_clean), 0);
    chk("rstw_nrel", n_rel, 2);
    btn_if.button_raw = 1'b0;
    step(4);
    reset = 1'b1;
    #2;
    chk("rstw_clean",   32'(btn_if.button_clean),  0);
    chk("rstw_press",   32'(btn_if.press_pulse),   0);
    chk("rstw_release", 32'(btn_if.release_pulse), 0);
    step(2);
    reset = 1'b0;
    step(6);
    chk("rstw_early_clean", 32'(btn_if.button_clean), 0);
    step(1);
    chk("rstw_clean2", 32'(btn_if.button_clean), 1);
    chk("rstw_pulse",  32'(btn_if.press_pulse),  1);
    step(2);
    chk("rstw_npress", n_press, 4);

`ifdef TROLLEY_BUTTON_LONG_PRESS_EN
    btn_if.button_raw = 1'b1;
    step(10);
    btn_if.button_raw = 1'b0;
    step(7);
    chk("lp_press_pulse", 32'(btn_if.press_pulse), 1);
    l0 = n_long;
    step(9);
    chk("lp_early", 32'(btn_if.long_press), 0);
    step(1);
    chk("lp_fire", 32'(btn_if.long_press), 1);
    step(1);
    chk("lp_width", 32'(btn_if.long_press), 0);
    step(20);
    chk("lp_once", n_long - l0, 1);
    btn_if.button_raw = 1'b1;
    step(10);
    btn_if.button_raw = 1'b0;
    step(7);
    l0 = n_long;
    step(10);
    chk("lp_rearm", 32'(btn_if.long_press), 1);
    step(2);
    chk("lp_rearm_cnt", n_long - l0, 1);
`else
    l0 = 0;
    chk("nolp_count", n_long, l0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/trolley_system_button_debounce.md
# trolley_system_button_debounce

Conditions one raw mechanical push-button input for the trolley system. It synchronises the pad signal into the `clk` domain, debounces it with a saturating hold counter and a four-state FSM, and drives a clean active-high level into the button PIO's `in_port`. It also produces single-cycle press/release strobes for local logic. It sits directly upstream of the button PIO: pad → this block → PIO `in_port` → Avalon readdata/irq.

## Interface
- `DEBOUNCE_CYCLES`, 500000: cycles the synchronised input must hold a new level before it is committed (10 ms at 50 MHz); legal range ≥ 2.
- `SYNC_STAGES`, 2: flip-flop stages in the input synchroniser; legal range ≥ 2.
- `RAW_ACTIVE_LOW`, 1: 1 means the pad reads 0 when pressed (board KEY); 0 means the pad reads 1 when pressed.
- `LONG_PRESS_CYCLES`, 100000000: held-pressed cycles before `long_press` fires; used only with the macro defined.
- `clk` in 1: system clock; the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `button_raw` in 1: asynchronous pad input.
- `button_clean` out 1: debounced level, 1 = pressed; feeds PIO `in_port`.
- `press_pulse` out 1: one-cycle strobe when `button_clean` rises.
- `release_pulse` out 1: one-cycle strobe when `button_clean` falls.
- `long_press` out 1: one-cycle strobe; present only with `TROLLEY_BUTTON_LONG_PRESS_EN`.

## Operation
- Normalisation: `pressed_raw = button_raw ^ RAW_ACTIVE_LOW`, so that 1 = pressed. This value passes through `SYNC_STAGES` flops to give `s`.
- FSM states:
  - RELEASED: `button_clean = 0`. If `s == 1`, go to WAIT_PRESS with `cnt = 0`.
  - WAIT_PRESS: if `s == 0`, return to RELEASED and clear `cnt`. Otherwise `cnt++`. When `cnt == DEBOUNCE_CYCLES-1` and `s == 1`, go to PRESSED.
  - PRESSED: `button_clean = 1`. If `s == 0`, go to WAIT_RELEASE with `cnt = 0`.
  - WAIT_RELEASE: mirror of WAIT_PRESS. Return to PRESSED if `s == 1`. Go to RELEASED once `cnt == DEBOUNCE_CYCLES-1` with `s == 0`.
- `button_clean` is registered and decoded from the state. It is 1 in PRESSED and WAIT_RELEASE, and 0 in RELEASED and WAIT_PRESS.
- Strobes are registered and aligned with the `button_clean` edge:
  - `press_pulse` is high in the first cycle `button_clean == 1`.
  - `release_pulse` is high in the first cycle `button_clean == 0` after a press.
- Counter width is `$clog2(DEBOUNCE_CYCLES)`. The counter never wraps, because it is cleared on every abort and every commit.
- Any bounce during a WAIT state restarts the full hold window. There is no partial credit.
- Reset values:
  - All outputs are 0.
  - State is RELEASED and `cnt = 0`.
  - Synchroniser flops reset to the released level (normalised 0), so a held-released pad never produces a pulse after reset.
- Reset mid-operation: everything returns to the reset values immediately. A button still held when reset is released is re-debounced from RELEASED and yields one `press_pulse` after the full window.

## Timing
- Latency: `button_clean` changes `SYNC_STAGES + DEBOUNCE_CYCLES` clock edges after the first edge that samples a stable new pad level.
- Strobes are exactly 1 cycle wide. They are never back-to-back: the minimum spacing is `DEBOUNCE_CYCLES + 1` cycles.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles, as seen at `s`, never changes `button_clean`.
- All outputs come directly from flops, with no combinational path from `button_raw`.

## Configuration
- `TROLLEY_BUTTON_LONG_PRESS_EN` defined:
  - Adds the `long_press` port and a second counter of width `$clog2(LONG_PRESS_CYCLES)`.
  - The counter clears on entry to PRESSED and increments while the state is PRESSED or WAIT_RELEASE.
  - `long_press` pulses for one cycle when the count reaches `LONG_PRESS_CYCLES-1`, at most once per press, and then saturates.
  - Returning to RELEASED re-arms it.
- Macro undefined: no `long_press` port and no second counter. All other behaviour is identical.

## Structure
- Package `trolley_system_button_pkg`:
  - the `btn_state_t` enum (RELEASED, WAIT_PRESS, PRESSED, WAIT_RELEASE);
  - default constants `BTN_DEBOUNCE_CYCLES_DEF`, `BTN_LONG_PRESS_CYCLES_DEF` and `BTN_SYNC_STAGES_DEF`.
- Sub-module `trolley_system_button_sync`: an N-stage reset-able synchroniser, parameterised by `SYNC_STAGES` and the reset value. It is reused for the other pad inputs.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, `SYNC_STAGES=2`, `RAW_ACTIVE_LOW=1` and `LONG_PRESS_CYCLES=10`.
- Clean press: drive `button_raw` 1→0 and hold → `button_clean` rises 6 edges later and `press_pulse` is high for exactly that cycle.
- Bounce: toggle `button_raw` 0/1 every 2 cycles for 20 cycles, then hold 0 → exactly one `press_pulse`, 6 edges after the final stable 0.
- Short glitch: `button_raw` low for 3 cycles, then high → `button_clean` stays 0 and there are no strobes.
- Release: from pressed, drive `button_raw` high and hold → `release_pulse` fires after 6 edges and `button_clean` = 0.
- Reset: assert `reset` while in WAIT_PRESS → all outputs are 0 immediately. Deassert with the pad still low → one `press_pulse` after a full 6-edge window.
- Long press (macro defined): hold pressed for 30 cycles → `long_press` fires once, 10 cycles after `press_pulse`. A release and re-press re-arms it.
